// File: rtl/saturating_counter.sv
// Up/down counter clamped to 0..RANGE-1; out-of-range requests are ignored, simultaneous requests cancel.
// Optional SATURATING_COUNTER_SATURATION_EVENTS_EN adds registered overflow/underflow attempt pulses.
module saturating_counter #(
  parameter int RANGE       = 4,
  parameter int RESET_VALUE = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  increment,
  input  logic                  decrement,
  output logic [$clog2(RANGE)-1:0] count,
`ifdef SATURATING_COUNTER_SATURATION_EVENTS_EN
  output logic                  overflow_attempt,
  output logic                  underflow_attempt,
`endif
  output logic                  is_minimum,
  output logic                  is_maximum
);

  localparam int RANGE_LOG2 = $clog2(RANGE);
  localparam logic [RANGE_LOG2-1:0] MAX_COUNT   = RANGE_LOG2'(RANGE - 1);
  localparam logic [RANGE_LOG2-1:0] RESET_COUNT = RANGE_LOG2'(RESET_VALUE);

  if (RANGE < 2 || RESET_VALUE < 0 || RESET_VALUE >= RANGE) begin : g_bad_params
    $error("saturating_counter: RANGE must be >= 2 and RESET_VALUE in 0..RANGE-1");
  end

  logic                  inc_only;
  logic                  dec_only;
  logic [RANGE_LOG2-1:0] count_next;

  assign is_minimum = (count == '0);
  assign is_maximum = (count == MAX_COUNT);
  assign inc_only   = increment & ~decrement;
  assign dec_only   = decrement & ~increment;

  // Bound checks gate the step, so values >= RANGE are never produced.
  always_comb begin
    count_next = count;
    if (inc_only && !is_maximum) begin
      count_next = count + RANGE_LOG2'(1);
    end else if (dec_only && !is_minimum) begin
      count_next = count - RANGE_LOG2'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= RESET_COUNT;
    end else begin
      count <= count_next;
    end
  end

`ifdef SATURATING_COUNTER_SATURATION_EVENTS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_attempt  <= 1'b0;
      underflow_attempt <= 1'b0;
    end else begin
      overflow_attempt  <= inc_only & is_maximum;
      underflow_attempt <= dec_only & is_minimum;
    end
  end
`endif

endmodule

// File: tb/tb_saturating_counter.sv
// Bench for saturating_counter: two instances (RANGE=4/RESET_VALUE=0 and RANGE=5/RESET_VALUE=2)
// share stimulus; a clamped reference model feeds an expected-value queue checked after each edge.
module tb_saturating_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       increment = 1'b0;
  logic       decrement = 1'b0;
  logic [1:0] count_a;
  logic [2:0] count_b;
  logic       min_a, max_a, min_b, max_b;
  logic       ovf_a, unf_a, ovf_b, unf_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int cnt_a;
    int ovf_a;
    int unf_a;
    int cnt_b;
    int ovf_b;
    int unf_b;
  } exp_t;

  exp_t exp_q[$];
  int   model_a = 0;
  int   model_b = 2;

  always #5 clock = ~clock;

  saturating_counter #(.RANGE(4), .RESET_VALUE(0)) dut_a (
    .clock            (clock),
    .reset            (reset),
    .increment        (increment),
    .decrement        (decrement),
    .count            (count_a),
`ifdef SATURATING_COUNTER_SATURATION_EVENTS_EN
    .overflow_attempt (ovf_a),
    .underflow_attempt(unf_a),
`endif
    .is_minimum       (min_a),
    .is_maximum       (max_a)
  );

  saturating_counter #(.RANGE(5), .RESET_VALUE(2)) dut_b (
    .clock            (clock),
    .reset            (reset),
    .increment        (increment),
    .decrement        (decrement),
    .count            (count_b),
`ifdef SATURATING_COUNTER_SATURATION_EVENTS_EN
    .overflow_attempt (ovf_b),
    .underflow_attempt(unf_b),
`endif
    .is_minimum       (min_b),
    .is_maximum       (max_b)
  );

`ifndef SATURATING_COUNTER_SATURATION_EVENTS_EN
  assign ovf_a = 1'b0;
  assign unf_a = 1'b0;
  assign ovf_b = 1'b0;
  assign unf_b = 1'b0;
`endif

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_next(input int cur, input int range, input bit inc, input bit dec);
    if (inc && !dec && cur < range - 1) return cur + 1;
    if (dec && !inc && cur > 0) return cur - 1;
    return cur;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, " count_a"}, int'(count_a), e.cnt_a);
    check({tag, " min_a"},   int'(min_a),   int'(e.cnt_a == 0));
    check({tag, " max_a"},   int'(max_a),   int'(e.cnt_a == 3));
    check({tag, " count_b"}, int'(count_b), e.cnt_b);
    check({tag, " min_b"},   int'(min_b),   int'(e.cnt_b == 0));
    check({tag, " max_b"},   int'(max_b),   int'(e.cnt_b == 4));
`ifdef SATURATING_COUNTER_SATURATION_EVENTS_EN
    check({tag, " ovf_a"}, int'(ovf_a), e.ovf_a);
    check({tag, " unf_a"}, int'(unf_a), e.unf_a);
    check({tag, " ovf_b"}, int'(ovf_b), e.ovf_b);
    check({tag, " unf_b"}, int'(unf_b), e.unf_b);
`endif
  endtask

  // Drive one request on the falling edge, queue the model's prediction, compare after the rising edge.
  task automatic step(input string tag, input bit inc, input bit dec);
    exp_t e;
    @(negedge clock);
    increment = inc;
    decrement = dec;
    e.ovf_a = int'(inc && !dec && model_a == 3);
    e.unf_a = int'(dec && !inc && model_a == 0);
    e.ovf_b = int'(inc && !dec && model_b == 4);
    e.unf_b = int'(dec && !inc && model_b == 0);
    model_a = model_next(model_a, 4, inc, dec);
    model_b = model_next(model_b, 5, inc, dec);
    e.cnt_a = model_a;
    e.cnt_b = model_b;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, " queue empty"}, 1, 0);
    end else begin
      check_outputs(tag, exp_q.pop_front());
    end
  endtask

  task automatic reset_check(input string tag);
    exp_t e;
    model_a = 0;
    model_b = 2;
    e = '{cnt_a: 0, ovf_a: 0, unf_a: 0, cnt_b: 2, ovf_b: 0, unf_b: 0};
    check_outputs(tag, e);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset_check("reset held");
    @(negedge clock);
    reset = 1'b0;
    step("post reset", 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) step("inc sweep", 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("dec sweep", 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step("inc to 2", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("both", 1'b1, 1'b1);
    step("inc to 3", 1'b1, 1'b0);
    step("hold at 3", 1'b0, 1'b0);

    // Reset lands between edges, with an increment pending, and must act before the next edge.
    @(negedge clock);
    increment = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    reset_check("async reset");
    @(posedge clock);
    #1;
    reset_check("reset over edge");
    @(negedge clock);
    reset = 1'b0;
    increment = 1'b0;
    step("after reset", 1'b0, 1'b0);

    for (int i = 0; i < 100; i++) begin
      step("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
